// File: rtl/system_reg_burst_ctrl.sv
// Burst command front end for the system register holder.
// Takes one command per burst on a valid/ready channel and streams write or
// read beats. Each beat address is decoded onto config_reg, status_in and
// enable_flag. One response pulse is returned per burst.
module system_reg_burst_ctrl #(
  parameter int unsigned                  DATA_WIDTH = 32,
  parameter int unsigned                  ADDR_WIDTH = 16,
  parameter int unsigned                  MAX_BURST  = 256,
  parameter logic [ADDR_WIDTH-1:0]        CFG_ADDR   = 'h0000,
  parameter logic [ADDR_WIDTH-1:0]        STS_ADDR   = 'h0004,
  parameter logic [ADDR_WIDTH-1:0]        EN_ADDR    = 'h0008
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  resp_valid,
  output logic                  resp_err,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] config_reg,
  output logic                  enable_flag,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_k;
  logic                  r_err;
  logic                  r_cmd_err;
  logic [DATA_WIDTH-1:0] r_cfg;
  logic                  r_en;

  logic                  w_cmd_hs;
  logic                  w_cmd_bad;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_last;
  logic                  w_hit_cfg;
  logic                  w_hit_sts;
  logic                  w_hit_en;
  logic                  w_busy;
  logic [DATA_WIDTH-1:0] w_rd_mux;

  // Handshake and beat-acceptance qualifiers
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_cmd_hs  = cmd_valid && !w_busy;
    w_cmd_bad = ({1'b0, cmd_len} >= 9'(MAX_BURST)) || (cmd_addr[1:0] != 2'b00);
    w_wr_acc  = (r_state == S_WRITE) && wr_valid;
    w_rd_acc  = (r_state == S_READ) && rd_ready;
    w_last    = (r_k == r_len);
  end

  // Address decode of the current beat
  always_comb begin
    w_hit_cfg = (r_addr == CFG_ADDR);
    w_hit_sts = (r_addr == STS_ADDR);
    w_hit_en  = (r_addr == EN_ADDR);
  end

  // Read data mux; status passes through live, other sources are static during a read
  always_comb begin
    w_rd_mux = '0;
    if (w_hit_cfg) begin
      w_rd_mux = r_cfg;
    end else if (w_hit_sts) begin
      w_rd_mux = status_in;
    end else if (w_hit_en) begin
      w_rd_mux = {{(DATA_WIDTH-1){1'b0}}, r_en};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and state-derived outputs
  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_next = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && w_last) begin
          w_next = S_RESP;
        end
      end
      S_READ: begin
        rd_valid = 1'b1;
        rd_data  = w_rd_mux;
        rd_last  = w_last;
        if (rd_ready && w_last) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Burst context: beat address, beat count, length and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_k       <= '0;
      r_err     <= 1'b0;
      r_cmd_err <= 1'b0;
    end else if (w_cmd_hs) begin
      r_addr    <= cmd_addr;
      r_len     <= cmd_len;
      r_k       <= '0;
      r_err     <= w_cmd_bad;
      r_cmd_err <= w_cmd_bad;
    end else if (w_wr_acc || w_rd_acc) begin
      // The address register walks by 4 per beat, equivalent to cmd_addr + 4*k with wrap.
      r_addr <= r_addr + ADDR_WIDTH'(4);
      r_k    <= r_k + 8'd1;
      if (w_wr_acc && !(w_hit_cfg || w_hit_en)) begin
        r_err <= 1'b1;
      end
      if (w_rd_acc && !(w_hit_cfg || w_hit_sts || w_hit_en)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Writable registers, updated on the accepting edge unless the command was rejected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg <= '0;
      r_en  <= 1'b0;
    end else if (w_wr_acc && !r_cmd_err) begin
      if (w_hit_cfg) begin
        r_cfg <= wr_data;
      end
      if (w_hit_en) begin
        r_en <= wr_data[0];
      end
    end
  end

  assign config_reg  = r_cfg;
  assign enable_flag = r_en;
  assign busy        = w_busy;

endmodule
